// File: rtl/mandala_sequencer.sv
// mandala_sequencer
// Frame-rate control sequencer for the mandala pattern generator. Once per
// frame (rising edge of vsync) it advances the animation and colour phases,
// counts the dwell time in the current mode and runs the ring-by-ring
// fade-out / mode change / fade-in sequence. The push buttons request a mode
// change or toggle pause.
//
// Ports
//   clk           pixel clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   vsync         active-high vertical sync, synchronous to clk
//   btn_next      asynchronous push button, request next mode
//   btn_pause     asynchronous push button, toggle pause
//   auto_en       asynchronous level, enables timed auto-advance
//   speed         pattern step select, step = 1 << speed
//   pattern_count animation phase for the angle term (wraps at 1024)
//   color_count   base-colour phase (wraps at 256)
//   mode          current pattern mode
//   layer_mask    per-ring enable, bit 0 innermost
//   frame_tick    one-cycle pulse per frame
//   fading        high while fading out or in
`timescale 1ns/1ps

module mandala_sequencer #(
  parameter int MODE_FRAMES = 240,
  parameter int NUM_MODES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto_en,
  input  logic [1:0] speed,
  output logic [9:0] pattern_count,
  output logic [7:0] color_count,
  output logic [2:0] mode,
  output logic [7:0] layer_mask,
  output logic       frame_tick,
  output logic       fading
);

  localparam int DWELL_W = (MODE_FRAMES > 1) ? $clog2(MODE_FRAMES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MODE_FRAMES - 1);
  localparam logic [2:0]         MODE_LAST  = 3'(NUM_MODES - 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_FADE_OUT = 2'd1;
  localparam logic [1:0] S_FADE_IN  = 2'd2;
  localparam logic [1:0] S_PAUSED   = 2'd3;

  function automatic logic [2:0] mode_inc(input logic [2:0] m);
    return (m == MODE_LAST) ? 3'd0 : m + 3'd1;
  endfunction

  // Dwell saturates so that enabling auto_en after a long manual stay
  // advances on the next frame instead of waiting for a counter wrap.
  function automatic logic [DWELL_W-1:0] dwell_inc(input logic [DWELL_W-1:0] d);
    return (d == DWELL_LAST) ? d : d + DWELL_W'(1);
  endfunction

  logic               vsync_d;
  logic               tick;
  logic               next_s0, next_s1, next_s2;
  logic               pause_s0, pause_s1, pause_s2;
  logic               auto_s0, auto_s1;
  logic               next_edge, pause_edge;
  logic               next_req, next_def, pause_req;
  logic [1:0]         state;
  logic [DWELL_W-1:0] dwell;
  logic [9:0]         step;

  logic [1:0]         state_nxt;
  logic [9:0]         pc_nxt;
  logic [7:0]         cc_nxt;
  logic [2:0]         mode_nxt;
  logic [7:0]         mask_nxt;
  logic [DWELL_W-1:0] dwell_nxt;
  logic               next_req_nxt, next_def_nxt, pause_req_nxt;

  assign tick       = vsync & ~vsync_d;
  assign next_edge  = next_s1 & ~next_s2;
  assign pause_edge = pause_s1 & ~pause_s2;
  assign step       = 10'd1 << speed;

  // next_def holds a next request that lost to a pause in RUN; it is only
  // honoured back in RUN, so it cannot step the mode while paused.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pattern_count;
    cc_nxt        = color_count;
    mode_nxt      = mode;
    mask_nxt      = layer_mask;
    dwell_nxt     = dwell;
    next_req_nxt  = next_req | next_edge;
    next_def_nxt  = next_def;
    pause_req_nxt = pause_req | pause_edge;
    if (tick) begin
      case (state)
        S_RUN: begin
          pc_nxt    = pattern_count + step;
          cc_nxt    = color_count + 8'd1;
          dwell_nxt = dwell_inc(dwell);
          if (pause_req) begin
            state_nxt     = S_PAUSED;
            pause_req_nxt = pause_edge;
            next_def_nxt  = next_def | next_req;
            next_req_nxt  = next_edge;
          end else if (next_req || next_def || (auto_s1 && dwell == DWELL_LAST)) begin
            // The advancing tick already drops the outermost ring.
            state_nxt    = S_FADE_OUT;
            mask_nxt     = layer_mask >> 1;
            dwell_nxt    = '0;
            next_req_nxt = next_edge;
            next_def_nxt = 1'b0;
          end
        end
        S_FADE_OUT: begin
          pc_nxt       = pattern_count + step;
          cc_nxt       = color_count + 8'd1;
          dwell_nxt    = '0;
          mask_nxt     = layer_mask >> 1;
          next_req_nxt = next_edge;
          next_def_nxt = 1'b0;
          if (layer_mask[7:1] == 7'h00) begin
            mode_nxt  = mode_inc(mode);
            state_nxt = S_FADE_IN;
          end
        end
        S_FADE_IN: begin
          pc_nxt       = pattern_count + step;
          cc_nxt       = color_count + 8'd1;
          dwell_nxt    = '0;
          mask_nxt     = {layer_mask[6:0], 1'b1};
          next_req_nxt = next_edge;
          next_def_nxt = 1'b0;
          if (layer_mask[6:0] == 7'h7F) begin
            state_nxt = S_RUN;
          end
        end
        default: begin
          mask_nxt = 8'hFF;
          if (pause_req) begin
            state_nxt     = S_RUN;
            pause_req_nxt = pause_edge;
          end else if (next_req) begin
            mode_nxt     = mode_inc(mode);
            dwell_nxt    = '0;
            next_req_nxt = next_edge;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d       <= 1'b0;
      frame_tick    <= 1'b0;
      next_s0       <= 1'b0;
      next_s1       <= 1'b0;
      next_s2       <= 1'b0;
      pause_s0      <= 1'b0;
      pause_s1      <= 1'b0;
      pause_s2      <= 1'b0;
      auto_s0       <= 1'b0;
      auto_s1       <= 1'b0;
      next_req      <= 1'b0;
      next_def      <= 1'b0;
      pause_req     <= 1'b0;
      state         <= S_RUN;
      pattern_count <= 10'd0;
      color_count   <= 8'd0;
      mode          <= 3'd0;
      layer_mask    <= 8'hFF;
      dwell         <= '0;
      fading        <= 1'b0;
    end else begin
      vsync_d       <= vsync;
      frame_tick    <= tick;
      next_s0       <= btn_next;
      next_s1       <= next_s0;
      next_s2       <= next_s1;
      pause_s0      <= btn_pause;
      pause_s1      <= pause_s0;
      pause_s2      <= pause_s1;
      auto_s0       <= auto_en;
      auto_s1       <= auto_s0;
      next_req      <= next_req_nxt;
      next_def      <= next_def_nxt;
      pause_req     <= pause_req_nxt;
      state         <= state_nxt;
      pattern_count <= pc_nxt;
      color_count   <= cc_nxt;
      mode          <= mode_nxt;
      layer_mask    <= mask_nxt;
      dwell         <= dwell_nxt;
      fading        <= (state_nxt == S_FADE_OUT) || (state_nxt == S_FADE_IN);
    end
  end

endmodule

// File: tb/tb_mandala_sequencer.sv
`timescale 1ns/1ps

module tb_mandala_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_pause = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] pattern_count;
  logic [7:0] color_count;
  logic [2:0] mode;
  logic [7:0] layer_mask;
  logic       frame_tick;
  logic       fading;

  mandala_sequencer #(.MODE_FRAMES(4), .NUM_MODES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .btn_next     (btn_next),
    .btn_pause    (btn_pause),
    .auto_en      (auto_en),
    .speed        (speed),
    .pattern_count(pattern_count),
    .color_count  (color_count),
    .mode         (mode),
    .layer_mask   (layer_mask),
    .frame_tick   (frame_tick),
    .fading       (fading)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pc;
    logic [7:0] cc;
    logic [2:0] md;
    logic [7:0] mk;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Ring mask after each of the 16 fade ticks, starting at the advancing tick.
  logic [7:0] fade_mask [16] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
                                 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int pc, input int cc, input int md, input int mk, input logic fd);
    exp_t e;
    e.pc = pc[9:0];
    e.cc = cc[7:0];
    e.md = md[2:0];
    e.mk = mk[7:0];
    e.fd = fd;
    exp_q.push_back(e);
  endtask

  // One frame: vsync high for one cycle; frame_tick must follow one cycle later
  // and last exactly one cycle.
  task automatic frame();
    repeat (3) @(posedge clk);
    #1 check("ft_idle", 32'(frame_tick), 32'd0);
    vsync = 1'b1;
    @(posedge clk);
    #1 check("ft_rise", 32'(frame_tick), 32'd1);
    vsync = 1'b0;
    @(posedge clk);
    #1 check("ft_fall", 32'(frame_tick), 32'd0);
  endtask

  task automatic press(input logic nxt, input logic pse);
    btn_next  = nxt;
    btn_pause = pse;
    repeat (2) @(posedge clk);
    #1;
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vsync     = 1'b0;
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    auto_en   = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pc",   32'(pattern_count), 32'd0);
    check("rst_cc",   32'(color_count),   32'd0);
    check("rst_mode", 32'(mode),          32'd0);
    check("rst_mask", 32'(layer_mask),    32'hFF);
    check("rst_ft",   32'(frame_tick),    32'd0);
    check("rst_fade", 32'(fading),        32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every frame_tick pulse is matched against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: pc=%0d cc=%0d mode=%0d mask=%h fading=%b, no frame expected",
                   pattern_count, color_count, mode, layer_mask, fading);
        end else begin
          e = exp_q.pop_front();
          if ({pattern_count, color_count, mode, layer_mask, fading} !== e) begin
            n_fail++;
            $display("FAIL frame: got pc=%0d cc=%0d mode=%0d mask=%h fading=%b, expected pc=%0d cc=%0d mode=%0d mask=%h fading=%b",
                     pattern_count, color_count, mode, layer_mask, fading,
                     e.pc, e.cc, e.md, e.mk, e.fd);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Three frames at speed 2.
    do_reset();
    speed = 2'd2;
    push(4, 1, 0, 8'hFF, 1'b0);  frame();
    push(8, 2, 0, 8'hFF, 1'b0);  frame();
    push(12, 3, 0, 8'hFF, 1'b0); frame();

    // Timed auto-advance, MODE_FRAMES = 4, step 1.
    do_reset();
    speed   = 2'd0;
    auto_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 3 || i == 20) push(i, i, (i == 20) ? 1 : 0, 8'hFF, 1'b0);
      else push(i, i, (i - 4 >= 7) ? 1 : 0, 32'(fade_mask[i - 4]), (i - 4 < 15));
      frame();
    end

    // Three next presses in one frame give one fade; a press mid-fade is dropped.
    do_reset();
    speed = 2'd0;
    push(1, 1, 0, 8'hFF, 1'b0); frame();
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
    for (int i = 2; i <= 18; i++) begin
      if (i == 5) press(1'b1, 1'b0);
      if (i == 18) push(i, i, 1, 8'hFF, 1'b0);
      else push(i, i, (i - 2 >= 7) ? 1 : 0, 32'(fade_mask[i - 2]), (i - 2 < 15));
      frame();
    end

    // Pause and next together: pause wins, next waits for RUN.
    do_reset();
    speed = 2'd1;
    push(2, 1, 0, 8'hFF, 1'b0); frame();
    press(1'b1, 1'b1);
    push(4, 2, 0, 8'hFF, 1'b0); frame();
    for (int i = 0; i < 5; i++) begin
      push(4, 2, 0, 8'hFF, 1'b0); frame();
    end
    press(1'b0, 1'b1);
    push(4, 2, 0, 8'hFF, 1'b0); frame();
    push(6, 3, 0, 8'h7F, 1'b1); frame();
    push(8, 4, 0, 8'h3F, 1'b1); frame();

    // Next while paused steps the mode directly, wrapping 7 -> 0.
    do_reset();
    speed = 2'd0;
    press(1'b0, 1'b1);
    push(1, 1, 0, 8'hFF, 1'b0); frame();
    for (int m = 1; m <= 8; m++) begin
      press(1'b1, 1'b0);
      push(1, 1, m % 8, 8'hFF, 1'b0); frame();
    end

    // Counter wrap at 1024 and 256, then asynchronous reset mid-fade.
    do_reset();
    speed = 2'd2;
    for (int i = 1; i <= 255; i++) begin
      push(4 * i, i, 0, 8'hFF, 1'b0); frame();
    end
    speed = 2'd3;
    push(4, 0, 0, 8'hFF, 1'b0); frame();
    press(1'b1, 1'b0);
    push(12, 1, 0, 8'h7F, 1'b1); frame();
    push(20, 2, 0, 8'h3F, 1'b1); frame();
    rst_n = 1'b0;
    #2;
    check("arst_mask", 32'(layer_mask),    32'hFF);
    check("arst_mode", 32'(mode),          32'd0);
    check("arst_fade", 32'(fading),        32'd0);
    check("arst_pc",   32'(pattern_count), 32'd0);
    check("arst_cc",   32'(color_count),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(8, 1, 0, 8'hFF, 1'b0); frame();

    repeat (3) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
